// File: rtl/line_mem_arbiter.sv
`default_nettype none
// line_mem_arbiter -- round-robin sharing of the line-wide DataMemory between
// the instruction cache (port 0) and the data cache (port 1). Rev 1.0
module line_mem_arbiter #(
  parameter int LINE_SIZE = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     r0_valid,
  input  logic [31:0]              r0_addr,
  input  logic                     r0_read,
  input  logic                     r0_write,
  input  logic [LINE_SIZE*8-1:0]   r0_din,
  output logic                     r0_grant,
  output logic                     r0_resp_valid,
  output logic [LINE_SIZE*8-1:0]   r0_dout,
  input  logic                     r1_valid,
  input  logic [31:0]              r1_addr,
  input  logic                     r1_read,
  input  logic                     r1_write,
  input  logic [LINE_SIZE*8-1:0]   r1_din,
  output logic                     r1_grant,
  output logic                     r1_resp_valid,
  output logic [LINE_SIZE*8-1:0]   r1_dout,
  output logic                     mem_is_input_valid,
  output logic [31:0]              mem_addr,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [LINE_SIZE*8-1:0]   mem_din,
  input  logic                     mem_is_output_valid,
  input  logic [LINE_SIZE*8-1:0]   mem_dout,
  input  logic                     mem_ready,
  output logic [CNT_WIDTH-1:0]     gnt_cnt0,
  output logic [CNT_WIDTH-1:0]     gnt_cnt1
);

  localparam int LINE_BITS = LINE_SIZE * 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]           state_q, state_d;
  logic                 win_q, win_d;
  logic                 last_q, last_d;
  logic [31:0]          addr_q, addr_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic [LINE_BITS-1:0] din_q, din_d;
  logic                 busy_seen_q, busy_seen_d;
  logic [LINE_BITS-1:0] dout0_q, dout0_d;
  logic [LINE_BITS-1:0] dout1_q, dout1_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

  logic pick;
  logic start;

  // On a tie the port that did not win last time takes the grant.
  always_comb begin
    pick = 1'b0;
    if (r0_valid && r1_valid) begin
      pick = ~last_q;
    end else if (r1_valid) begin
      pick = 1'b1;
    end
  end

  assign start = (state_q == S_IDLE) && mem_ready && (r0_valid || r1_valid);

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    last_d      = last_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    din_d       = din_q;
    busy_seen_d = busy_seen_q;
    dout0_d     = dout0_q;
    dout1_d     = dout1_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          win_d  = pick;
          addr_d = pick ? r1_addr : r0_addr;
          wr_d   = pick ? r1_write : r0_write;
          rd_d   = (pick ? r1_read : r0_read) & ~wr_d;
          din_d  = pick ? r1_din : r0_din;
          if (pick) begin
            cnt1_d = (cnt1_q == CNT_MAX) ? cnt1_q : cnt1_q + 1'b1;
          end else begin
            cnt0_d = (cnt0_q == CNT_MAX) ? cnt0_q : cnt0_q + 1'b1;
          end
          state_d = (rd_d || wr_d) ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        busy_seen_d = 1'b0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // A write is done only once the memory has been seen busy and then idle again.
        if (wr_q) begin
          if (mem_ready && busy_seen_q) begin
            state_d = S_RESP;
          end else if (!mem_ready) begin
            busy_seen_d = 1'b1;
          end
        end else if (mem_is_output_valid) begin
          if (win_q) begin
            dout1_d = mem_dout;
          end else begin
            dout0_d = mem_dout;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        last_d  = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      win_q       <= 1'b0;
      last_q      <= 1'b0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      din_q       <= '0;
      busy_seen_q <= 1'b0;
      dout0_q     <= '0;
      dout1_q     <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      din_q       <= din_d;
      busy_seen_q <= busy_seen_d;
      dout0_q     <= dout0_d;
      dout1_q     <= dout1_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign r0_grant           = start && !pick && !reset;
  assign r1_grant           = start && pick && !reset;
  assign r0_resp_valid      = (state_q == S_RESP) && !win_q && !reset;
  assign r1_resp_valid      = (state_q == S_RESP) && win_q && !reset;
  assign r0_dout            = dout0_q;
  assign r1_dout            = dout1_q;
  assign mem_is_input_valid = (state_q == S_ISSUE) && !reset;
  assign mem_addr           = addr_q;
  assign mem_read           = rd_q;
  assign mem_write          = wr_q;
  assign mem_din            = din_q;
  assign gnt_cnt0           = cnt0_q;
  assign gnt_cnt1           = cnt1_q;

endmodule
`default_nettype wire

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Two-port round-robin arbiter that shares the single line-wide DataMemory between the instruction cache (port 0) and the data cache (port 1).
- Accepts whole-line refill reads and writeback writes from each cache.
- Serialises them onto the DataMemory request interface, one transaction at a time.
- Returns each completion to the port that issued it. Sits between the two cache controllers and the DataMemory instance.

Parameters:
LINE_SIZE, 16, line size in bytes; LINE_BITS = LINE_SIZE*8 (128 by default) is the width of every data bus.
CNT_WIDTH, 16, width of the per-port grant counters.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
r0_valid  input  1  port 0 request pending; held high with fields stable until r0_resp_valid
r0_addr  input  32  port 0 line address
r0_read  input  1  port 0 line read
r0_write  input  1  port 0 line write
r0_din  input  LINE_BITS  port 0 write data
r0_grant  output  1  one-cycle pulse: port 0 request latched
r0_resp_valid  output  1  one-cycle pulse: port 0 transaction complete
r0_dout  output  LINE_BITS  port 0 read data, valid with r0_resp_valid
r1_* (valid, addr, read, write, din, grant, resp_valid, dout)  same as port 0, for port 1
mem_is_input_valid  output  1  DataMemory request strobe
mem_addr  output  32  DataMemory address
mem_read  output  1  DataMemory read
mem_write  output  1  DataMemory write
mem_din  output  LINE_BITS  DataMemory write data
mem_is_output_valid  input  1  DataMemory read data valid
mem_dout  input  LINE_BITS  DataMemory read data
mem_ready  input  1  DataMemory idle and able to accept a request
gnt_cnt0  output  CNT_WIDTH  saturating count of port 0 grants
gnt_cnt1  output  CNT_WIDTH  saturating count of port 1 grants

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; last_grant=0, so port 1 wins the first tie.
  - All mem_* outputs 0; all grant and resp pulses 0; r0_dout and r1_dout 0; counters 0; busy_seen=0.
  - Reset mid-transaction abandons it. No response is issued. The DataMemory request is not retracted beyond dropping mem_is_input_valid.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Leaves only when mem_ready=1 and at least one rN_valid=1.
  - Winner: the only valid port; if both are valid, the port != last_grant.
  - Latch winner id, addr, read, write and din; pulse rN_grant for that cycle; increment gnt_cntN, saturating at all-ones.
  - If the latched read=0 and write=0 (null op): go to RESP directly. Otherwise go to ISSUE.
- ISSUE:
  - Exactly one cycle: mem_is_input_valid=1 with the latched fields.
  - If both read and write are latched, drive mem_write=1 and mem_read=0 (write wins).
  - Clear busy_seen; go to WAIT.
  - mem_addr, mem_din, mem_read and mem_write hold their latched values through WAIT and RESP. mem_is_input_valid is 0 outside ISSUE.
- WAIT:
  - Read transaction: when mem_is_output_valid=1, latch mem_dout into the winner's rN_dout and go to RESP.
  - Write transaction: set busy_seen on any cycle with mem_ready=0. Complete on the first cycle with mem_ready=1 and busy_seen=1 (that cycle included), then go to RESP.
  - No timeout.
- RESP:
  - One cycle: rN_resp_valid=1 for the winner only.
  - rN_dout holds the last read data for that port; writes and null ops leave it unchanged.
  - Set last_grant=winner; go to IDLE.
- The requester may drop rN_valid in the cycle after resp_valid. If valid is still high in IDLE, it is a new request.
- Simultaneous events:
  - A request arriving during ISSUE, WAIT or RESP waits in IDLE; it is not latched early.
  - Valid changes on the non-winning port never affect the transaction in flight.
- Minimum latency, request-to-resp: null op 2 cycles. Read: 3 cycles plus DataMemory read latency.
- Fairness: under continuous requests from both ports, grants strictly alternate. Neither port waits more than one foreign transaction.

Test Plan:
- Single read: r1_valid, r1_read, addr=0x40; memory returns 0xAA..AA after 4 cycles. Expected: r1_grant pulse, then mem_is_input_valid for one cycle, then r1_resp_valid with r1_dout=0xAA..AA; gnt_cnt1=1.
- Tie after reset: r0 reads 0x00 and r1 reads 0x80, both valid at the same cycle. Expected: port 1 served first, port 0 second; gnt_cnt0=1 and gnt_cnt1=1.
- Sustained contention: both ports request continuously for 6 transactions. Expected: grant order 1,0,1,0,1,0; r0_resp_valid never asserted for a port-1 transaction.
- Write completion: r0 write, addr=0x100, din=0x1234..; mem_ready low for 3 cycles then high. Expected: r0_resp_valid in the cycle after mem_ready returns high; r0_dout unchanged.
- Null op plus both-set: r1_valid with read=0 and write=0 gives r1_resp_valid 2 cycles after request, with no mem_is_input_valid. r0 with read=1 and write=1 drives mem_write=1 and mem_read=0.
- Reset in WAIT: assert reset during a pending read. Expected: next cycle state IDLE, all pulses 0, counters 0, and no resp_valid when the stale mem_is_output_valid arrives.
